// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

    localparam logic [5:0] OPC_J   = 6'b000010;
    localparam int         INSTR_W = 32;
    localparam int         PC_W    = 32;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO of fetched {pc, instr} entries
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_clear,
    input  fetch_entry_t                 i_data,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // clear (and reset) win over any push/pop in the same cycle
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner, ROM addressing and fetch queue toward decode
// Optional self-jump halt enabled by FETCH_SELF_JUMP_HALT_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 6,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [INSTR_W-1:0]  rom_dout,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [PC_W-1:0]     out_pc,
    output logic                halted
);

    localparam int CNT_W = $clog2(QDEPTH + 1);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_redirect_pc;
    logic              w_fetch;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    fetch_entry_t      w_entry;
    fetch_entry_t      w_head;
    logic              w_unused;

    assign rom_addr      = r_pc[ADDR_W+1:2];
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
    assign w_pop         = out_valid & out_ready;
    assign w_entry.pc    = r_pc;
    assign w_entry.instr = rom_dout;
    assign out_valid     = ~w_empty;
    assign out_pc        = w_head.pc;
    assign out_instr     = w_head.instr;
    assign w_unused      = &{1'b0, w_count};

`ifdef FETCH_SELF_JUMP_HALT_EN
    logic w_self_jump;
    assign w_self_jump = (rom_dout[31:26] == OPC_J) && (rom_dout[25:0] == r_pc[27:2]);
    assign halted      = (r_state == ST_HALT);
`else
    assign halted      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fetch     = 1'b0;
        if (redirect_valid) begin
            w_state_nxt = ST_RUN;
        end else if ((r_state == ST_RUN) && (!w_full || w_pop)) begin
            w_fetch = 1'b1;
`ifdef FETCH_SELF_JUMP_HALT_EN
            if (w_self_jump) begin
                w_state_nxt = ST_HALT;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_pc;
        end else if (w_fetch) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_clear (redirect_valid),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
